// File: rtl/umi_req_arbiter.sv
// Round-robin arbiter that shares one UMI endpoint port among N requesters.
// A tag FIFO of requester indices routes responses back in issue order.
module umi_req_arbiter #(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int CW    = 32,
    parameter int AW    = 64,
    parameter int DW    = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    uhost_req_valid,
    input  logic [N*CW-1:0] uhost_req_cmd,
    input  logic [N*AW-1:0] uhost_req_dstaddr,
    input  logic [N*AW-1:0] uhost_req_srcaddr,
    input  logic [N*DW-1:0] uhost_req_data,
    output logic [N-1:0]    uhost_req_ready,
    output logic [N-1:0]    uhost_resp_valid,
    output logic [CW-1:0]   uhost_resp_cmd,
    output logic [AW-1:0]   uhost_resp_dstaddr,
    output logic [AW-1:0]   uhost_resp_srcaddr,
    output logic [DW-1:0]   uhost_resp_data,
    input  logic [N-1:0]    uhost_resp_ready,
    output logic            udev_req_valid,
    output logic [CW-1:0]   udev_req_cmd,
    output logic [AW-1:0]   udev_req_dstaddr,
    output logic [AW-1:0]   udev_req_srcaddr,
    output logic [DW-1:0]   udev_req_data,
    input  logic            udev_req_ready,
    input  logic            udev_resp_valid,
    input  logic [CW-1:0]   udev_resp_cmd,
    input  logic [AW-1:0]   udev_resp_dstaddr,
    input  logic [AW-1:0]   udev_resp_srcaddr,
    input  logic [DW-1:0]   udev_resp_data,
    output logic            udev_resp_ready,
    output logic            err_orphan
);
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = PW + 1;
    // UMI request opcodes in cmd[4:0] that expect a response
    localparam logic [4:0] OP_READ  = 5'h01;
    localparam logic [4:0] OP_WRITE = 5'h03;

    logic [CW-1:0] cmd_arr [N];
    logic [AW-1:0] dst_arr [N];
    logic [AW-1:0] src_arr [N];
    logic [DW-1:0] dat_arr [N];
    logic [N-1:0]  re;
    logic [N-1:0]  elig;

    logic [IW-1:0]   ptr_q, ptr_d;
    logic            lock_q, lock_d;
    logic [IW-1:0]   lock_idx_q, lock_idx_d;
    logic [IW-1:0]   fifo_q [DEPTH];
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            orphan_q, orphan_d;

    logic          full, empty, rr_found, win_vld, hs, push, pop;
    logic [IW:0]   cand_sum;
    logic [IW-1:0] rr_idx, win_idx, head;

    assign full  = (count_q == CNTW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = fifo_q[rd_q];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_req
            assign cmd_arr[gi] = uhost_req_cmd[gi*CW +: CW];
            assign dst_arr[gi] = uhost_req_dstaddr[gi*AW +: AW];
            assign src_arr[gi] = uhost_req_srcaddr[gi*AW +: AW];
            assign dat_arr[gi] = uhost_req_data[gi*DW +: DW];
            assign re[gi]      = (cmd_arr[gi][4:0] == OP_READ) || (cmd_arr[gi][4:0] == OP_WRITE);
            assign elig[gi]    = uhost_req_valid[gi] & (~re[gi] | ~full);
            assign uhost_req_ready[gi]  = udev_req_ready & win_vld & (win_idx == IW'(gi));
            assign uhost_resp_valid[gi] = ~empty & udev_resp_valid & (head == IW'(gi));
        end
    endgenerate

    // First eligible index at or after ptr, wrapping modulo N
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand_sum = '0;
        for (int k = 0; k < N; k++) begin
            cand_sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand_sum >= (IW+1)'(N)) begin
                cand_sum = cand_sum - (IW+1)'(N);
            end
            if (!rr_found && elig[cand_sum[IW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand_sum[IW-1:0];
            end
        end
    end

    assign win_idx = lock_q ? lock_idx_q : rr_idx;
    assign win_vld = lock_q | rr_found;
    assign hs      = win_vld & udev_req_ready;
    assign push    = hs & re[win_idx];
    assign pop     = ~empty & udev_resp_valid & udev_resp_ready;

    assign udev_req_valid   = win_vld;
    assign udev_req_cmd     = cmd_arr[win_idx];
    assign udev_req_dstaddr = dst_arr[win_idx];
    assign udev_req_srcaddr = src_arr[win_idx];
    assign udev_req_data    = dat_arr[win_idx];

    // With no outstanding tag the response is an orphan and is dropped
    assign udev_resp_ready    = empty ? udev_resp_valid : uhost_resp_ready[head];
    assign uhost_resp_cmd     = udev_resp_cmd;
    assign uhost_resp_dstaddr = udev_resp_dstaddr;
    assign uhost_resp_srcaddr = udev_resp_srcaddr;
    assign uhost_resp_data    = udev_resp_data;
    assign err_orphan         = orphan_q;

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        orphan_d   = orphan_q | (empty & udev_resp_valid);
        if (hs) begin
            ptr_d  = (win_idx == IW'(N-1)) ? '0 : win_idx + 1'b1;
            lock_d = 1'b0;
        end else if (win_vld) begin
            lock_d     = 1'b1;
            lock_idx_d = win_idx;
        end
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            orphan_q   <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            orphan_q   <= orphan_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= win_idx;
    end
endmodule

// File: tb/tb_umi_req_arbiter.sv
// Bench for umi_req_arbiter: queue-based reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_umi_req_arbiter;
    localparam int N = 4, DEPTH = 4, CW = 32, AW = 64, DW = 256;
    localparam logic [4:0] OP_RD = 5'h01, OP_WR = 5'h03, OP_PW = 5'h05;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]    uhost_req_valid = '0;
    logic [N*CW-1:0] uhost_req_cmd = '0;
    logic [N*AW-1:0] uhost_req_dstaddr = '0;
    logic [N*AW-1:0] uhost_req_srcaddr = '0;
    logic [N*DW-1:0] uhost_req_data = '0;
    logic [N-1:0]    uhost_req_ready;
    logic [N-1:0]    uhost_resp_valid;
    logic [CW-1:0]   uhost_resp_cmd;
    logic [AW-1:0]   uhost_resp_dstaddr, uhost_resp_srcaddr;
    logic [DW-1:0]   uhost_resp_data;
    logic [N-1:0]    uhost_resp_ready = '0;
    logic            udev_req_valid;
    logic [CW-1:0]   udev_req_cmd;
    logic [AW-1:0]   udev_req_dstaddr, udev_req_srcaddr;
    logic [DW-1:0]   udev_req_data;
    logic            udev_req_ready = 1'b0;
    logic            udev_resp_valid = 1'b0;
    logic [CW-1:0]   udev_resp_cmd = 32'h0000_0002;
    logic [AW-1:0]   udev_resp_dstaddr = 64'h1234;
    logic [AW-1:0]   udev_resp_srcaddr = 64'h5678;
    logic [DW-1:0]   udev_resp_data = {8{32'hCAFE_F00D}};
    logic            udev_resp_ready;
    logic            err_orphan;

    int pass_cnt = 0;
    int total_cnt = 0;
    int seq = 0;

    umi_req_arbiter #(.N(N), .DEPTH(DEPTH), .CW(CW), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(rst),
        .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
        .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
        .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
        .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
        .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
        .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready),
        .udev_req_valid(udev_req_valid), .udev_req_cmd(udev_req_cmd),
        .udev_req_dstaddr(udev_req_dstaddr), .udev_req_srcaddr(udev_req_srcaddr),
        .udev_req_data(udev_req_data), .udev_req_ready(udev_req_ready),
        .udev_resp_valid(udev_resp_valid), .udev_resp_cmd(udev_resp_cmd),
        .udev_resp_dstaddr(udev_resp_dstaddr), .udev_resp_srcaddr(udev_resp_srcaddr),
        .udev_resp_data(udev_resp_data), .udev_resp_ready(udev_resp_ready),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] op);
        seq++;
        uhost_req_valid[i] = v;
        uhost_req_cmd[i*CW +: CW]     = {8'(seq), 8'h00, 8'(i + 1), 3'b000, op};
        uhost_req_dstaddr[i*AW +: AW] = {32'hD000_0000 + 32'(i), 32'(seq)};
        uhost_req_srcaddr[i*AW +: AW] = {32'h5000_0000 + 32'(i), 32'(seq)};
        uhost_req_data[i*DW +: DW]    = {8{32'(seq * 16 + i)}};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: state as it will be after the next rising edge
    int m_ptr = 0;
    bit m_lock = 0;
    int m_lock_idx = 0;
    int m_tags[$];
    bit m_orphan = 0;

    function automatic bit is_re(input int i);
        logic [CW-1:0] c;
        c = uhost_req_cmd[i*CW +: CW];
        return (c[4:0] == OP_RD) || (c[4:0] == OP_WR);
    endfunction

    always @(negedge clk) begin
        bit found;
        int win;
        logic [N-1:0] exp_rdy, exp_rv;
        logic exp_dready;
        if (rst) begin
            m_ptr = 0; m_lock = 0; m_lock_idx = 0; m_tags.delete(); m_orphan = 0;
        end
        found = 0; win = 0;
        if (m_lock) begin
            found = 1; win = m_lock_idx;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!found && uhost_req_valid[c] && (!is_re(c) || m_tags.size() < DEPTH)) begin
                    found = 1; win = c;
                end
            end
        end
        exp_rdy = '0;
        if (found && udev_req_ready) exp_rdy[win] = 1'b1;
        exp_rv = '0;
        if (m_tags.size() == 0) begin
            exp_dready = udev_resp_valid;
        end else begin
            if (udev_resp_valid) exp_rv[m_tags[0]] = 1'b1;
            exp_dready = uhost_resp_ready[m_tags[0]];
        end
        chk("udev_req_valid", 64'(udev_req_valid), 64'(found));
        chk("uhost_req_ready", 64'(uhost_req_ready), 64'(exp_rdy));
        chk("uhost_resp_valid", 64'(uhost_resp_valid), 64'(exp_rv));
        chk("udev_resp_ready", 64'(udev_resp_ready), 64'(exp_dready));
        chk("err_orphan", 64'(err_orphan), 64'(m_orphan));
        chk("resp_payload", 64'((uhost_resp_data == udev_resp_data) && (uhost_resp_cmd == udev_resp_cmd)
                                && (uhost_resp_dstaddr == udev_resp_dstaddr)
                                && (uhost_resp_srcaddr == udev_resp_srcaddr)), 64'd1);
        if (found) begin
            chk("udev_req_cmd", 64'(udev_req_cmd), 64'(uhost_req_cmd[win*CW +: CW]));
            chk("udev_req_dstaddr", udev_req_dstaddr, uhost_req_dstaddr[win*AW +: AW]);
            chk("udev_req_srcaddr", udev_req_srcaddr, uhost_req_srcaddr[win*AW +: AW]);
            chk("udev_req_data", 64'(udev_req_data == uhost_req_data[win*DW +: DW]), 64'd1);
        end
        if (!rst) begin
            if (m_tags.size() == 0 && udev_resp_valid) m_orphan = 1;
            if (m_tags.size() != 0 && udev_resp_valid && exp_dready) void'(m_tags.pop_front());
            if (found && udev_req_ready) begin
                m_ptr = (win + 1) % N;
                m_lock = 0;
                if (is_re(win)) m_tags.push_back(win);
            end else if (found) begin
                m_lock = 1; m_lock_idx = win;
            end
        end
    end

    initial begin
        logic [3:0] fair_exp [5];
        fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        step(); #2;
        chk("rst_req_valid", 64'(udev_req_valid), 64'd0);
        chk("rst_req_ready", 64'(uhost_req_ready), 64'd0);
        chk("rst_resp_valid", 64'(uhost_resp_valid), 64'd0);
        chk("rst_resp_ready", 64'(udev_resp_ready), 64'd0);
        chk("rst_orphan", 64'(err_orphan), 64'd0);
        step();
        rst = 1'b0;

        // Fairness with posted writes
        for (int i = 0; i < N; i++) set_req(i, 1'b1, OP_PW);
        udev_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2 chk("fair_grant", 64'(uhost_req_ready), 64'(fair_exp[k]));
            step();
        end
        uhost_req_valid = '0;
        set_req(3, 1'b1, OP_PW);
        #2 chk("ptr_move_grant3", 64'(uhost_req_ready), 64'b1000);
        step();
        uhost_req_valid = '0;

        // Lock under stall: ptr is 0, requester 2 alone, then 0 joins
        udev_req_ready = 1'b0;
        set_req(2, 1'b1, OP_PW);
        #2 chk("lock_c1_cmd", 64'(udev_req_cmd), 64'(uhost_req_cmd[2*CW +: CW]));
        step();
        set_req(0, 1'b1, OP_PW);
        #2 chk("lock_c2_cmd", 64'(udev_req_cmd), 64'(uhost_req_cmd[2*CW +: CW]));
        step();
        #2 chk("lock_c3_cmd", 64'(udev_req_cmd), 64'(uhost_req_cmd[2*CW +: CW]));
        step();
        udev_req_ready = 1'b1;
        #2 chk("lock_release", 64'(uhost_req_ready), 64'b0100);
        step();
        uhost_req_valid[2] = 1'b0;
        #2 chk("after_lock_grant0", 64'(uhost_req_ready), 64'b0001);
        step();
        uhost_req_valid = '0;

        // FIFO full with reads from requester 1
        set_req(1, 1'b1, OP_RD);
        for (int k = 0; k < DEPTH; k++) begin
            #2 chk("fill_grant1", 64'(uhost_req_ready), 64'b0010);
            step();
        end
        #2 chk("full_stall_ready", 64'(uhost_req_ready), 64'b0000);
        chk("full_stall_valid", 64'(udev_req_valid), 64'd0);
        set_req(3, 1'b1, OP_PW);
        #2 chk("full_posted_pass", 64'(uhost_req_ready), 64'b1000);
        step();
        uhost_req_valid[3] = 1'b0;
        udev_resp_valid = 1'b1;
        uhost_resp_ready = 4'b0010;
        #2 chk("full_resp_valid", 64'(uhost_resp_valid), 64'b0010);
        chk("full_resp_ready", 64'(udev_resp_ready), 64'd1);
        chk("full_same_cycle", 64'(uhost_req_ready), 64'b0000);
        step();
        udev_resp_valid = 1'b0;
        #2 chk("full_freed", 64'(uhost_req_ready), 64'b0010);
        step();
        uhost_req_valid = '0;
        udev_resp_valid = 1'b1;
        uhost_resp_ready = 4'b1111;
        repeat (DEPTH) step();
        udev_resp_valid = 1'b0;
        #2 chk("drained_resp_ready", 64'(udev_resp_ready), 64'd0);

        // Out-of-order issue 3,0,2; responses return in issue order
        set_req(3, 1'b1, OP_RD); step(); uhost_req_valid = '0;
        set_req(0, 1'b1, OP_WR); step(); uhost_req_valid = '0;
        set_req(2, 1'b1, OP_RD); step(); uhost_req_valid = '0;
        udev_resp_valid = 1'b1;
        #2 chk("ooo_resp3", 64'(uhost_resp_valid), 64'b1000);
        step();
        uhost_resp_ready = 4'b1110;
        #2 chk("ooo_resp0_hold", 64'(uhost_resp_valid), 64'b0001);
        chk("ooo_stall1", 64'(udev_resp_ready), 64'd0);
        step();
        #2 chk("ooo_stall2", 64'(udev_resp_ready), 64'd0);
        step();
        uhost_resp_ready = 4'b1111;
        #2 chk("ooo_resp0", 64'(uhost_resp_valid), 64'b0001);
        chk("ooo_resp0_ready", 64'(udev_resp_ready), 64'd1);
        step();
        #2 chk("ooo_resp2", 64'(uhost_resp_valid), 64'b0100);
        step();
        udev_resp_valid = 1'b0;

        // Orphan with empty FIFO
        udev_resp_valid = 1'b1;
        #2 chk("orphan_ready", 64'(udev_resp_ready), 64'd1);
        chk("orphan_no_valid", 64'(uhost_resp_valid), 64'd0);
        chk("orphan_not_yet", 64'(err_orphan), 64'd0);
        step();
        udev_resp_valid = 1'b0;
        #2 chk("orphan_set", 64'(err_orphan), 64'd1);
        step();
        #2 chk("orphan_sticky", 64'(err_orphan), 64'd1);

        // Reset with two tags outstanding
        set_req(0, 1'b1, OP_RD); step(); uhost_req_valid = '0;
        set_req(1, 1'b1, OP_RD); step(); uhost_req_valid = '0;
        rst = 1'b1;
        #2 chk("midrst_orphan", 64'(err_orphan), 64'd0);
        chk("midrst_resp_valid", 64'(uhost_resp_valid), 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, OP_PW);
        #2 chk("midrst_ptr0", 64'(uhost_req_ready), 64'b0001);
        step();
        uhost_req_valid = '0;
        udev_resp_valid = 1'b1;
        #2 chk("midrst_orphan_ready", 64'(udev_resp_ready), 64'd1);
        chk("midrst_orphan_novalid", 64'(uhost_resp_valid), 64'd0);
        step();
        udev_resp_valid = 1'b0;
        #2 chk("midrst_orphan_set", 64'(err_orphan), 64'd1);
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
